// File: rtl/alu_cmd_driver.sv
// Registers one command into the combinational ALU, waits SETTLE_CYCLES, then returns the result.
// Error ops respond without touching the ALU. cmd_ready is high only in IDLE; rsp_valid holds until rsp_ready.
module alu_cmd_driver #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [3:0]  cmd_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_op,
  input  logic [8:0]  alu_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [8:0]  rsp_data,
  output logic        rsp_err,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] OP_DIV      = 4'b0011;
  localparam logic [3:0] OP_LAST     = 4'b1011;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  alu_a_q, alu_a_d;
  logic [7:0]  alu_b_q, alu_b_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic [8:0]  rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic [15:0] op_count_q, op_count_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    op_count_d = op_count_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_op > OP_LAST) begin
            rsp_data_d = 9'h000;
            rsp_err_d  = 1'b1;
            state_d    = RESP;
          end else if (cmd_op == OP_DIV && cmd_b == 8'd0) begin
            rsp_data_d = 9'h1FF;
            rsp_err_d  = 1'b1;
            state_d    = RESP;
          end else begin
            alu_a_d  = cmd_a;
            alu_b_d  = cmd_b;
            alu_op_d = cmd_op;
            cnt_d    = SETTLE_INIT;
            state_d  = ISSUE;
          end
        end
      end
      ISSUE: begin
        // ALU inputs have been stable for SETTLE_CYCLES edges once cnt reaches zero
        if (cnt_q == 4'd0) begin
          rsp_data_d = alu_out;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          op_count_d = op_count_q + 16'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      alu_a_q    <= 8'd0;
      alu_b_q    <= 8'd0;
      alu_op_q   <= 4'd0;
      rsp_data_q <= 9'd0;
      rsp_err_q  <= 1'b0;
      op_count_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      op_count_q <= op_count_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver: one instance with settle=1, one with settle=3, each fed by a small ALU model.
module tb_alu_cmd_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // settle = 1 instance
  logic        r1_n, c1_vld, c1_rdy, s1_vld, s1_rdy, s1_err;
  logic [7:0]  c1_a, c1_b, a1_a, a1_b;
  logic [3:0]  c1_op, a1_op;
  logic [8:0]  a1_out, s1_dat;
  logic [15:0] n1;

  // settle = 3 instance
  logic        r3_n, c3_vld, c3_rdy, s3_vld, s3_rdy, s3_err;
  logic [7:0]  c3_a, c3_b, a3_a, a3_b;
  logic [3:0]  c3_op, a3_op;
  logic [8:0]  a3_out, s3_dat;
  logic [15:0] n3;

  function automatic logic [8:0] alu_model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (op)
      4'd0:    return {1'b0, a} + {1'b0, b};
      4'd1:    return {1'b0, a} - {1'b0, b};
      4'd2:    return p[8:0];
      4'd3:    return (b == 8'd0) ? 9'h1FF : {1'b0, a / b};
      4'd4:    return {1'b0, a & b};
      4'd5:    return {1'b0, a | b};
      4'd6:    return {1'b0, a ^ b};
      4'd7:    return {1'b0, ~a};
      4'd8:    return {a, 1'b0};
      4'd9:    return {2'b0, a[7:1]};
      4'd10:   return {1'b0, a} + 9'd1;
      4'd11:   return {1'b0, a} - 9'd1;
      default: return 9'd0;
    endcase
  endfunction

  assign a1_out = alu_model(a1_a, a1_b, a1_op);
  assign a3_out = alu_model(a3_a, a3_b, a3_op);

  alu_cmd_driver #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(r1_n),
    .cmd_valid(c1_vld), .cmd_ready(c1_rdy), .cmd_a(c1_a), .cmd_b(c1_b), .cmd_op(c1_op),
    .alu_a(a1_a), .alu_b(a1_b), .alu_op(a1_op), .alu_out(a1_out),
    .rsp_valid(s1_vld), .rsp_ready(s1_rdy), .rsp_data(s1_dat), .rsp_err(s1_err),
    .op_count(n1)
  );

  alu_cmd_driver #(.SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(r3_n),
    .cmd_valid(c3_vld), .cmd_ready(c3_rdy), .cmd_a(c3_a), .cmd_b(c3_b), .cmd_op(c3_op),
    .alu_a(a3_a), .alu_b(a3_b), .alu_op(a3_op), .alu_out(a3_out),
    .rsp_valid(s3_vld), .rsp_ready(s3_rdy), .rsp_data(s3_dat), .rsp_err(s3_err),
    .op_count(n3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd1(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    c1_a = a; c1_b = b; c1_op = op; c1_vld = 1'b1;
    step();
    c1_vld = 1'b0;
  endtask

  task automatic cmd3(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    c3_a = a; c3_b = b; c3_op = op; c3_vld = 1'b1;
    step();
    c3_vld = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    r1_n = 1'b0; c1_vld = 1'b0; c1_a = '0; c1_b = '0; c1_op = '0; s1_rdy = 1'b0;
    r3_n = 1'b0; c3_vld = 1'b0; c3_a = '0; c3_b = '0; c3_op = '0; s3_rdy = 1'b0;
    step(); step();
    check("rst_rsp_valid", 32'(s1_vld), 0);
    check("rst_rsp_data",  32'(s1_dat), 0);
    check("rst_rsp_err",   32'(s1_err), 0);
    check("rst_alu",       {12'd0, a1_a, a1_b, a1_op}, 0);
    check("rst_op_count",  32'(n1), 0);
    r1_n = 1'b1; r3_n = 1'b1;
    step();
    check("rst_cmd_ready", 32'(c1_rdy), 1);

    // add 200+100, response consumed immediately
    s1_rdy = 1'b1;
    cmd1(8'd200, 8'd100, 4'b0000);
    check("add_alu_op",    32'(a1_op), 0);
    check("add_alu_a",     32'(a1_a), 200);
    check("add_alu_b",     32'(a1_b), 100);
    check("add_busy",      32'(c1_rdy), 0);
    check("add_no_rsp_t0", 32'(s1_vld), 0);
    step();
    check("add_rsp_valid", 32'(s1_vld), 1);
    check("add_rsp_data",  32'(s1_dat), 'h12C);
    check("add_rsp_err",   32'(s1_err), 0);
    check("add_cnt_pre",   32'(n1), 0);
    step();
    check("add_op_count",  32'(n1), 1);
    check("add_idle_rdy",  32'(c1_rdy), 1);
    check("add_rsp_drop",  32'(s1_vld), 0);
    step(); step();
    check("idle_rsp_ready_noop", 32'(n1), 1);

    // sub 5-10 with 5 cycles of backpressure and an ignored command
    s1_rdy = 1'b0;
    cmd1(8'd5, 8'd10, 4'b0001);
    c1_a = 8'd99; c1_b = 8'd1; c1_op = 4'b0010; c1_vld = 1'b1;
    step();
    check("sub_rsp_valid", 32'(s1_vld), 1);
    check("sub_rsp_data",  32'(s1_dat), 'h1FB);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid_hold", 32'(s1_vld), 1);
      check("bp_data_hold",  32'(s1_dat), 'h1FB);
      check("bp_cmd_ready",  32'(c1_rdy), 0);
    end
    c1_vld = 1'b0; s1_rdy = 1'b1;
    step();
    check("bp_op_count",   32'(n1), 2);
    check("bp_ignored_op", 32'(a1_op), 1);
    check("bp_ignored_a",  32'(a1_a), 5);

    // divide by zero: ALU inputs keep the sub operands
    s1_rdy = 1'b0;
    cmd1(8'd7, 8'd0, 4'b0011);
    step();
    check("dz_rsp_valid", 32'(s1_vld), 1);
    check("dz_rsp_data",  32'(s1_dat), 'h1FF);
    check("dz_rsp_err",   32'(s1_err), 1);
    check("dz_alu_keep",  {12'd0, a1_a, a1_b, a1_op}, {12'd0, 8'd5, 8'd10, 4'd1});
    s1_rdy = 1'b1;
    step();
    check("dz_op_count",  32'(n1), 3);

    // illegal opcode
    s1_rdy = 1'b0;
    cmd1(8'd1, 8'd2, 4'b1100);
    step();
    check("ill_rsp_valid", 32'(s1_vld), 1);
    check("ill_rsp_data",  32'(s1_dat), 0);
    check("ill_rsp_err",   32'(s1_err), 1);
    check("ill_alu_keep",  32'(a1_op), 1);
    s1_rdy = 1'b1;
    step();
    check("ill_op_count",  32'(n1), 4);

    // counter wrap from a preloaded value
    force u_dut1.op_count_q = 16'hFFFE;
    step();
    release u_dut1.op_count_q;
    step();
    check("wrap_preload", 32'(n1), 'hFFFE);
    cmd1(8'd0, 8'd0, 4'b1111);
    step(); step();
    check("wrap_ffff", 32'(n1), 'hFFFF);
    cmd1(8'd0, 8'd0, 4'b1110);
    step(); step();
    check("wrap_zero", 32'(n1), 0);

    // settle = 3: mul 15*17
    s3_rdy = 1'b1;
    cmd3(8'd15, 8'd17, 4'b0010);
    check("mul_busy_t0",  32'(c3_rdy), 0);
    check("mul_alu_op",   32'(a3_op), 2);
    step();
    check("mul_no_rsp_t1", 32'(s3_vld), 0);
    step();
    check("mul_no_rsp_t2", 32'(s3_vld), 0);
    check("mul_busy_t2",   32'(c3_rdy), 0);
    step();
    check("mul_rsp_valid", 32'(s3_vld), 1);
    check("mul_rsp_data",  32'(s3_dat), 'h0FF);
    check("mul_rsp_err",   32'(s3_err), 0);
    check("mul_busy_t3",   32'(c3_rdy), 0);
    step();
    check("mul_ready_back", 32'(c3_rdy), 1);
    check("mul_op_count",   32'(n3), 1);

    // reset while in ISSUE
    cmd3(8'd1, 8'd2, 4'b0000);
    step();
    step();
    r3_n = 1'b0;
    #1;
    check("rst_issue_alu",   {12'd0, a3_a, a3_b, a3_op}, 0);
    check("rst_issue_vld",   32'(s3_vld), 0);
    check("rst_issue_data",  32'(s3_dat), 0);
    check("rst_issue_count", 32'(n3), 0);
    step();
    r3_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rst_no_rsp", 32'(s3_vld), 0);
    end
    check("rst_ready_after", 32'(c3_rdy), 1);
    check("rst_count_after", 32'(n3), 0);
    cmd3(8'hF0, 8'h3C, 4'b0110);
    step(); step(); step();
    check("post_rst_valid", 32'(s3_vld), 1);
    check("post_rst_data",  32'(s3_dat), 'h0CC);
    step();
    check("post_rst_count", 32'(n3), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
